// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game engine: synchronises enter, places marks, detects win/draw (TTT_AUTO_RESTART_EN = restart on enter after game over).
// Enter rise -> board write after ENTER_SYNC_STG+1 cycles, flags/turn one cycle later; no backpressure, extra requests are rejected or dropped.
module ttt_board_ctrl #(
  parameter logic FIRST_PLAYER   = 1'b0,
  parameter int   ENTER_SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  square_num,
  input  logic        enter,
  output logic [17:0] board,
  output logic        player_turn,
  output logic [3:0]  move_count,
  output logic        illegal_move,
  output logic        player_1_win,
  output logic        player_2_win,
  output logic        draw,
  output logic        game_over
);

  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_e;

  state_e                    state_q, state_d;
  logic [ENTER_SYNC_STG-1:0] sync_q, sync_d;
  logic                      sync_prev_q, sync_prev_d;
  logic [17:0]               board_q, board_d;
  logic                      turn_q, turn_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      ill_q, ill_d;
  logic                      p1_q, p1_d;
  logic                      p2_q, p2_d;
  logic                      draw_q, draw_d;
  logic                      req;
  logic                      sq_free;
  logic [1:0]                mover_mark;

  // Squares are 0-indexed internally: square k of the port lives at bit pair k-1.
  function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] own;
    for (int k = 0; k < 9; k++) begin
      own[k] = (b[2*k +: 2] == m);
    end
    return (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
           (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
           (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
           (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
  endfunction

  always_comb begin
    sync_d      = {sync_q[ENTER_SYNC_STG-2:0], enter};
    sync_prev_d = sync_q[ENTER_SYNC_STG-1];
    req         = sync_q[ENTER_SYNC_STG-1] & ~sync_prev_q;
  end

  always_comb begin
    sq_free = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (square_num == 8'(k + 1)) begin
        sq_free = (board_q[2*k +: 2] == 2'b00);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    cnt_d      = cnt_q;
    ill_d      = 1'b0;
    p1_d       = p1_q;
    p2_d       = p2_q;
    draw_d     = draw_q;
    mover_mark = turn_q ? 2'b10 : 2'b01;
    case (state_q)
      PLAY: begin
        if (req) begin
          if (sq_free) begin
            for (int k = 0; k < 9; k++) begin
              if (square_num == 8'(k + 1)) begin
                board_d[2*k +: 2] = mover_mark;
              end
            end
            cnt_d   = (cnt_q >= 4'd9) ? 4'd9 : cnt_q + 4'd1;
            state_d = CHECK;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      CHECK: begin
        // A completed line on the ninth move is a win, so it is tested first.
        if (has_line(board_q, mover_mark)) begin
          if (turn_q) begin
            p2_d = 1'b1;
          end else begin
            p1_d = 1'b1;
          end
          state_d = WIN;
        end else if (cnt_q == 4'd9) begin
          draw_d  = 1'b1;
          state_d = DRAW;
        end else begin
          turn_d  = ~turn_q;
          state_d = PLAY;
        end
      end
      WIN, DRAW: begin
        if (req) begin
`ifdef TTT_AUTO_RESTART_EN
          board_d = '0;
          turn_d  = FIRST_PLAYER;
          cnt_d   = '0;
          p1_d    = 1'b0;
          p2_d    = 1'b0;
          draw_d  = 1'b0;
          state_d = PLAY;
`else
          ill_d = 1'b1;
`endif
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= PLAY;
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      board_q     <= '0;
      turn_q      <= FIRST_PLAYER;
      cnt_q       <= '0;
      ill_q       <= 1'b0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      board_q     <= board_d;
      turn_q      <= turn_d;
      cnt_q       <= cnt_d;
      ill_q       <= ill_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      draw_q      <= draw_d;
    end
  end

  assign board        = board_q;
  assign player_turn  = turn_q;
  assign move_count   = cnt_q;
  assign illegal_move = ill_q;
  assign player_1_win = p1_q;
  assign player_2_win = p2_q;
  assign draw         = draw_q;
  assign game_over    = p1_q | p2_q | draw_q;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Directed-vector bench for ttt_board_ctrl: one table record per enter press, plus latency and async-reset sequences.
module tb_ttt_board_ctrl;

  localparam logic FP  = 1'b0;
  localparam int   STG = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  square_num;
  logic        enter;
  logic [17:0] board;
  logic        player_turn;
  logic [3:0]  move_count;
  logic        illegal_move;
  logic        player_1_win;
  logic        player_2_win;
  logic        draw;
  logic        game_over;

  ttt_board_ctrl #(.FIRST_PLAYER(FP), .ENTER_SYNC_STG(STG)) dut (
    .clk(clk), .clr(clr), .square_num(square_num), .enter(enter),
    .board(board), .player_turn(player_turn), .move_count(move_count),
    .illegal_move(illegal_move), .player_1_win(player_1_win),
    .player_2_win(player_2_win), .draw(draw), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [7:0]  sq;
    logic [17:0] board;
    logic        turn;
    logic [3:0]  cnt;
    int          ill;
    logic [2:0]  flags;   // {p1_win, p2_win, draw}
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   mv_draw[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
  int   mv_diag[9] = '{2, 1, 4, 3, 6, 7, 8, 9, 5};

  function automatic logic [17:0] sqv(input int k, input logic [1:0] p);
    logic [17:0] r;
    r = '0;
    r[2*k-2 +: 2] = p;
    return r;
  endfunction

  task automatic add(input logic rst, input logic [7:0] sq, input logic [17:0] b,
                     input logic t, input logic [3:0] c, input int ill, input logic [2:0] f);
    vec_t v;
    v = '{rst, sq, b, t, c, ill, f};
    vecs.push_back(v);
  endtask

  // Enter pressed on a finished game.
  task automatic add_over(input logic [17:0] b, input logic t, input logic [3:0] c, input logic [2:0] f);
`ifdef TTT_AUTO_RESTART_EN
    add(1'b0, 8'd9, 18'h0, FP, 4'd0, 0, 3'b000);
`else
    add(1'b0, 8'd9, b, t, c, 1, f);
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    enter = 1'b0;
    square_num = 8'd0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  // One press: square held through the request cycle, then scrambled.
  task automatic press(input logic [7:0] sq, output int ill);
    ill = 0;
    @(negedge clk);
    square_num = sq;
    enter = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (illegal_move) ill++;
    end
    square_num = 8'hFF;
    enter = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (illegal_move) ill++;
    end
  endtask

  function automatic logic [31:0] pack_out(input int ill);
    return {3'b0, 2'(ill > 3 ? 3 : ill), board, player_turn, move_count,
            player_1_win, player_2_win, draw, game_over};
  endfunction

  function automatic logic [31:0] pack_exp(input vec_t v);
    return {3'b0, 2'(v.ill > 3 ? 3 : v.ill), v.board, v.turn, v.cnt, v.flags, |v.flags};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [17:0] b;
    int ill;
    clr = 1'b0;
    enter = 1'b0;
    square_num = 8'd0;

    // Game A: top-row win for P1.
    b = sqv(1, 2'b01);                   add(1'b1, 8'd1, b, 1'b1, 4'd1, 0, 3'b000);
    b = b | sqv(4, 2'b10);               add(1'b0, 8'd4, b, 1'b0, 4'd2, 0, 3'b000);
    b = b | sqv(2, 2'b01);               add(1'b0, 8'd2, b, 1'b1, 4'd3, 0, 3'b000);
    b = b | sqv(5, 2'b10);               add(1'b0, 8'd5, b, 1'b0, 4'd4, 0, 3'b000);
    b = b | sqv(3, 2'b01);               add(1'b0, 8'd3, b, 1'b0, 4'd5, 0, 3'b100);
    add_over(b, 1'b0, 4'd5, 3'b100);
    // Game B: illegal requests leave everything untouched.
    b = sqv(5, 2'b01);                   add(1'b1, 8'd5, b, 1'b1, 4'd1, 0, 3'b000);
    add(1'b0, 8'd5,   b, 1'b1, 4'd1, 1, 3'b000);
    add(1'b0, 8'd0,   b, 1'b1, 4'd1, 1, 3'b000);
    add(1'b0, 8'd12,  b, 1'b1, 4'd1, 1, 3'b000);
    add(1'b0, 8'd10,  b, 1'b1, 4'd1, 1, 3'b000);
    add(1'b0, 8'd255, b, 1'b1, 4'd1, 1, 3'b000);
    b = b | sqv(9, 2'b10);               add(1'b0, 8'd9, b, 1'b0, 4'd2, 0, 3'b000);
    // Game C: full board, no line -> draw with P1 as last mover.
    b = '0;
    for (int i = 0; i < 9; i++) begin
      b = b | sqv(mv_draw[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      add(i == 0, 8'(mv_draw[i]), b, (i == 8) ? 1'b0 : (i % 2 == 0), 4'(i + 1), 0,
          (i == 8) ? 3'b001 : 3'b000);
    end
    add_over(b, 1'b0, 4'd9, 3'b001);
    // Game D: P1 completes row 456 and column 258 on the ninth move.
    b = '0;
    for (int i = 0; i < 9; i++) begin
      b = b | sqv(mv_diag[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      add(i == 0, 8'(mv_diag[i]), b, (i == 8) ? 1'b0 : (i % 2 == 0), 4'(i + 1), 0,
          (i == 8) ? 3'b100 : 3'b000);
    end
    add_over(b, 1'b0, 4'd9, 3'b100);

    do_reset();
    check("reset_state", pack_out(0), {5'b0, 18'h0, FP, 4'd0, 4'b0000});

    // Latency of the first move from the enter rise.
    @(negedge clk);
    square_num = 8'd1;
    enter = 1'b1;
    repeat (STG) @(negedge clk);
    check("lat_before_write", {14'b0, board}, 32'h0);
    @(negedge clk);
    check("lat_write", {9'b0, board, player_turn, move_count}, {9'b0, sqv(1, 2'b01), 1'b0, 4'd1});
    @(negedge clk);
    check("lat_turn", {31'b0, player_turn}, 32'd1);
    enter = 1'b0;
    square_num = 8'hFF;
    repeat (3) @(negedge clk);
    press(8'd5, ill);
    check("mid_game", pack_out(ill),
          {5'b0, sqv(1, 2'b01) | sqv(5, 2'b10), 1'b0, 4'd2, 4'b0000});

    // Asynchronous reset: outputs clear with no clock edge.
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("async_reset", pack_out(0), {5'b0, 18'h0, FP, 4'd0, 4'b0000});

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      press(vecs[i].sq, ill);
      check($sformatf("vec%0d_sq%0d", i, vecs[i].sq), pack_out(ill), pack_exp(vecs[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
